// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and post-processing helpers for the conv
// accumulate/ReLU block.
//   DEF_* localparams  default widths, output shift and window length
//   round_shift()      arithmetic right shift with round-half-up
//   relu_sat()         clamp to [0, 2^ow-1]; returns {sat, value}
package cnn_pkg;

  localparam int DEF_PROD_WIDTH = 30;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_BIAS_WIDTH = 16;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_SHIFT      = 8;
  localparam int DEF_MAX_BEATS  = 25;

  // Operates on a 64-bit signed value so any accumulator up to 63 bits can
  // add the rounding constant without overflow.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int sh);
    logic signed [63:0] half;
    half = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
    return (v + half) >>> sh;
  endfunction

  function automatic logic [64:0] relu_sat(input logic signed [63:0] r,
                                           input int ow);
    logic signed [63:0] maxv;
    maxv = (64'sd1 <<< ow) - 64'sd1;
    if (r < 64'sd0)
      return 65'd0;
    else if (r > maxv)
      return {1'b1, maxv};
    else
      return {1'b0, r};
  endfunction

endpackage

// File: rtl/cnn_acc_post.sv
// cnn_acc_post: combinational round / rescale / ReLU / saturate of a
// finished window sum.
//   i_fin   signed window sum (ACC_WIDTH)
//   o_data  unsigned activation (OUT_WIDTH)
//   o_sat   activation was clipped to all ones
module cnn_acc_post
  import cnn_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic signed [ACC_WIDTH-1:0] i_fin,
  output logic        [OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);

  logic signed [63:0] w_fin64;
  logic signed [63:0] w_r;
  logic        [64:0] w_res;

  always_comb begin
    w_fin64 = 64'(i_fin);
    w_r     = round_shift(w_fin64, SHIFT);
    w_res   = relu_sat(w_r, OUT_WIDTH);
    o_data  = w_res[OUT_WIDTH-1:0];
    o_sat   = w_res[64];
  end

endmodule

// File: rtl/cnn_conv_acc_relu.sv
// cnn_conv_acc_relu: accumulates one kernel window of sign-magnitude
// products plus bias, then rounds, rescales, applies ReLU and saturates.
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          product beat handshake
//   in_prod, in_neg, in_last   product magnitude, subtract flag, window end
//   bias                       signed bias, sampled on first beat of window
//   out_valid/out_ready        activation handshake
//   out_data, out_sat          activation and clip flag
//   err_len                    sticky: window longer than MAX_BEATS
module cnn_conv_acc_relu
  import cnn_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [PROD_WIDTH-1:0] in_prod,
  input  logic                         in_neg,
  input  logic                         in_last,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         err_len
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic signed [ACC_WIDTH-1:0] r_acc_p0;
  logic        [CNT_W-1:0]     r_cnt_p0;
  logic                        r_first_p0;
  logic signed [ACC_WIDTH-1:0] r_fin_p1;
  logic                        r_vld_p1;
  logic                        r_vld_p2;
  logic        [OUT_WIDTH-1:0] r_data_p2;
  logic                        r_sat_p2;
  logic                        r_err_len;

  logic signed [ACC_WIDTH-1:0] w_acc_base;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic                        w_beat;
  logic                        w_move;
  logic        [OUT_WIDTH-1:0] w_post_data;
  logic                        w_post_sat;

  // Stage 1 frees whenever stage 2 is empty or draining, so the producer
  // only stalls when both result registers hold data and the consumer stalls.
  assign in_ready   = !r_vld_p1 || !r_vld_p2 || out_ready;
  assign w_beat     = in_valid && in_ready;
  assign w_move     = r_vld_p1 && (!r_vld_p2 || out_ready);

  assign w_acc_base = r_first_p0 ? ACC_WIDTH'(bias) : r_acc_p0;
  assign w_prod_ext = $signed(ACC_WIDTH'(in_prod));
  assign w_acc_next = in_neg ? (w_acc_base - w_prod_ext) : (w_acc_base + w_prod_ext);

  // ---- stage p0: accumulate beats of the current window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_p0   <= '0;
      r_cnt_p0   <= '0;
      r_first_p0 <= 1'b1;
      r_err_len  <= 1'b0;
    end else if (w_beat) begin
      r_acc_p0   <= w_acc_next;
      r_first_p0 <= in_last;
      r_cnt_p0   <= in_last ? '0 : r_cnt_p0 + CNT_W'(1);
      if (r_cnt_p0 == CNT_W'(MAX_BEATS - 1) && !in_last)
        r_err_len <= 1'b1;
    end
  end

  // ---- stage p1: finished window sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fin_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_beat && in_last) begin
      r_fin_p1 <= w_acc_next;
      r_vld_p1 <= 1'b1;
    end else if (w_move) begin
      r_vld_p1 <= 1'b0;
    end
  end

  cnn_acc_post #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_post (
    .i_fin  (r_fin_p1),
    .o_data (w_post_data),
    .o_sat  (w_post_sat)
  );

  // ---- stage p2: registered activation toward the pooling stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_sat_p2  <= 1'b0;
    end else if (w_move) begin
      r_vld_p2  <= 1'b1;
      r_data_p2 <= w_post_data;
      r_sat_p2  <= w_post_sat;
    end else if (out_ready) begin
      r_vld_p2  <= 1'b0;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_sat   = r_sat_p2;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// tb_cnn_conv_acc_relu: directed stimulus with a scoreboard queue of
// expected activations, compared as the DUT hands them off.
module tb_cnn_conv_acc_relu;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic        [29:0] in_prod;
  logic               in_neg;
  logic               in_last;
  logic signed [15:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic        [15:0] out_data;
  logic               out_sat;
  logic               err_len;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb_q[$];   // {sat, data}
  longint      m_acc;
  bit          m_first;

  logic        hold;
  logic [15:0] hold_data;
  logic        hold_sat;

  cnn_conv_acc_relu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_neg    (in_neg),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: floor((v + 128) / 256), then clamp to [0, 65535].
  function automatic logic [16:0] expect_of(input longint v);
    longint t;
    longint r;
    t = v + 128;
    if (t >= 0) r = t / 256;
    else        r = -((-t + 255) / 256);
    if (r < 0)          return 17'd0;
    else if (r > 65535) return {1'b1, 16'hFFFF};
    else                return {1'b0, r[15:0]};
  endfunction

  // Entered at posedge+1; leaves at posedge+1 after the beat is accepted.
  task automatic beat(input logic [29:0] p, input logic neg, input logic last,
                      input logic signed [15:0] b);
    int waited;
    in_valid = 1'b1;
    in_prod  = p;
    in_neg   = neg;
    in_last  = last;
    bias     = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
    end
    if (m_first) m_acc = longint'(b);
    m_acc   = neg ? m_acc - longint'(p) : m_acc + longint'(p);
    m_first = last;
    if (last) sb_q.push_back(expect_of(m_acc));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drain_q"}, sb_q.size(), 0);
  endtask

  // Output monitor: compares each handed-off activation with the scoreboard
  // and checks that a stalled output holds steady.
  always @(negedge clk) begin
    logic [16:0] e;
    if (hold && !reset) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_data);
      check("hold_sat", out_sat, hold_sat);
    end
    if (out_valid && out_ready && !reset) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output data=%0d required=none", out_data);
      end else begin
        e = sb_q.pop_front();
        check("out_data", out_data, e[15:0]);
        check("out_sat", out_sat, e[16]);
      end
    end
    hold      = out_valid && !out_ready && !reset;
    hold_data = out_data;
    hold_sat  = out_sat;
  end

  initial begin
    hold      = 1'b0;
    hold_data = '0;
    hold_sat  = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_neg    = 1'b0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    m_acc     = 0;
    m_first   = 1'b1;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_err_len", err_len, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 256 + 512 -> 3, valid one edge after the finishing edge
    beat(30'd256, 1'b0, 1'b0, 16'sd0);
    beat(30'd512, 1'b0, 1'b1, 16'sd0);
    check("t1_lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check("t1_lat_valid", out_valid, 1);
    check("t1_data", out_data, 3);
    drain("t1");

    // bias taken from first beat only: 300 + 100 - 50 = 350 -> 1
    beat(30'd100, 1'b0, 1'b0, 16'sd300);
    beat(30'd50,  1'b1, 1'b1, -16'sd5000);
    drain("bias_hold");

    // 2: 384/256 = 1.5 rounds up to 2
    beat(30'd384, 1'b0, 1'b1, 16'sd0);
    drain("t2");

    // 3: 100 - 1000 -> negative -> 0
    beat(30'd1000, 1'b1, 1'b1, 16'sd100);
    drain("t3");

    // 4: 2^29 -> 2^21 -> clipped
    beat(30'h2000_0000, 1'b0, 1'b1, 16'sd0);
    drain("t4");

    // negative bias with rounding exactly at -0.5: -128 -> 0
    beat(30'd0, 1'b0, 1'b1, -16'sd128);
    drain("neg_half");

    // 5: stalled consumer, three single-beat windows
    out_ready = 1'b0;
    beat(30'd256, 1'b0, 1'b1, 16'sd0);
    beat(30'd768, 1'b0, 1'b1, 16'sd0);
    in_valid = 1'b1;
    in_prod  = 30'd1280;
    in_neg   = 1'b0;
    in_last  = 1'b1;
    bias     = 16'sd0;
    #1;
    check("t5_stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t5_stall_ready_hold", in_ready, 0);
      check("t5_stall_valid", out_valid, 1);
      check("t5_stall_first", out_data, 1);
    end
    out_ready = 1'b1;
    #1;
    check("t5_release_ready", in_ready, 1);
    beat(30'd1280, 1'b0, 1'b1, 16'sd0);
    drain("t5");

    // 6: overlong window, then reset mid-window
    for (int i = 0; i < 24; i++) beat(30'd1, 1'b0, 1'b0, 16'sd0);
    check("t6_no_err_24", err_len, 0);
    beat(30'd1, 1'b0, 1'b0, 16'sd0);
    beat(30'd1, 1'b0, 1'b0, 16'sd0);
    check("t6_err_26", err_len, 1);
    check("t6_last_data_nonzero", out_data, 5);
    reset = 1'b1;
    #1;
    check("t6_rst_in_ready", in_ready, 1);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_out_sat", out_sat, 0);
    check("t6_rst_err_len", err_len, 0);
    sb_q.delete();
    m_first = 1'b1;
    m_acc   = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    beat(30'd256, 1'b0, 1'b1, 16'sd0);
    @(posedge clk); #1;
    check("t6_after_rst_data", out_data, 1);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
